pipeline: RTL and testbench
===========================

PIPELINE -- requirements
Module: pipeline

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 i_rst_n  input  1  synchronous, active-high reset (asserted = 1), sampled on rising clk.
REQ-003 i_we_IF  input  1  instruction-load strobe; i_instruction_data is written to instruction memory while high.
REQ-004 i_instruction_data  input  32  instruction word to load.
REQ-005 i_halt  input  1  freeze; while high no pipeline register, PC or memory updates.
REQ-006 o_jump, o_branch, o_regDst, o_mem2reg, o_memRead, o_memWrite, o_immediate_flag, o_sign_flag, o_regWrite  output  1 each  ID-stage control decode.
REQ-007 o_aluSrc  output  2  00 = rt register, 01 = sign-extended imm, 10 = zero-extended imm.
REQ-008 o_width  output  2  00 = byte, 01 = half, 10 = word; only word is used.
REQ-009 o_aluOp  output  2  00 = add, 01 = sub, 10 = R-type by funct, 11 = logical imm.
REQ-010 o_addr2jump  output  32  ID-computed jump/branch target.
REQ-011 o_reg_DA, o_reg_DB  output  32 each  register-file read data for rs/rt in ID, with WB bypass.
REQ-012 o_opcode 6, o_func 6, o_shamt 5, o_rs 5, o_rt 5, o_rd 5, o_immediate 16  outputs  instruction fields of the IF/ID word.
REQ-013 o_ALUresult  output  32  EX/MEM ALU result.
REQ-014 o_fwA, o_fwB  output  2 each  EX forwarding select: 00 = ID/EX, 10 = EX/MEM, 01 = MEM/WB.
REQ-015 o_data2mem 32, o_dataAddr 8  outputs  MEM-stage store data and byte address (ALU result [7:0]).
REQ-016 o_write_dataWB2ID 32, o_reg2writeWB2ID 5, o_write_enable 1  outputs  WB-stage write-back data, destination, enable.

Function
REQ-017 Five stages IF, ID, EX, MEM, WB with registers IF/ID, ID/EX, EX/MEM, MEM/WB; instruction in IF at cycle n writes back in cycle n+4.
REQ-018 Instruction memory 64 x 32; load pointer starts at 0 and increments by 1 per i_we_IF cycle, wrapping 63 -> 0.
REQ-019 While i_we_IF = 1 or i_halt = 1 the pipeline is frozen (PC and stage registers hold); i_we_IF has priority.
REQ-020 PC is a byte address, +4 per advancing cycle; fetch index PC[7:2]; unwritten words read 0 (NOP).
REQ-021 Supported: R-type ADD, SUB, AND, OR, XOR, SLT, SLL, SRL (shamt); ADDI, ANDI, ORI, LW, SW, BEQ, BNE, J; others decode as NOP with all controls 0.
REQ-022 ADD/SUB/ADDI wrap modulo 2^32 (no overflow trap); SLT signed; ANDI/ORI zero-extend (o_sign_flag = 0), others sign-extend.
REQ-023 Register file 32 x 32; $0 reads 0 and ignores writes; WB write is visible to the same-cycle ID read.
REQ-024 Branch/jump resolved in ID; taken -> PC = o_addr2jump and IF/ID flushed to NOP (1 bubble); BEQ/BNE target = PC+4 + (simm << 2), J target = {PC+4[31:28], target26, 00}.
REQ-025 Forwarding: EX/MEM has priority over MEM/WB; forward only when source regWrite = 1 and destination != 0.
REQ-026 Load-use hazard (LW in EX, rs/rt match in ID): stall PC and IF/ID for 1 cycle, insert bubble into ID/EX.
REQ-027 Data memory 256 bytes, word access at o_dataAddr with [1:0] ignored; SW writes in MEM, LW data registered into MEM/WB.

Reset
REQ-028 On reset: PC, load pointer, all pipeline registers and all outputs = 0; data memory cleared; register $i = i (i = 0..31); instruction memory retained.
REQ-029 Reset asserted mid-operation aborts all in-flight instructions the next edge; reset overrides i_we_IF and i_halt.

Verification
REQ-030 Reset, load ADD $3,$1,$2 (0x00221820), run -> o_write_enable = 1, o_reg2writeWB2ID = 3, o_write_dataWB2ID = 3 four cycles after fetch.
REQ-031 ADD $3,$1,$2 then SUB $4,$3,$1 -> o_fwA = 10 in SUB's EX, WB writes $4 = 2.
REQ-032 SW $2,8($1) then LW $5,8($1) -> o_dataAddr = 9 masked to word 8, o_data2mem = 2, WB writes $5 = 2.
REQ-033 LW $6,0($0) then ADD $7,$6,$1 -> one-cycle stall, then o_fwA = 01, $7 = 1.
REQ-034 i_halt high 3 cycles mid-program -> all outputs hold; resumes with identical results; BEQ $0,$0,+2 -> one flushed slot, target PC+12.

Source files
------------

// File: rtl/pipeline.sv
// Five-stage MIPS-subset pipeline: ID-resolved branches, EX forwarding,
// load-use stall, host-loaded instruction memory and a halt freeze.
module pipeline (
   input  logic        clk,
   input  logic        i_rst_n,
   input  logic        i_we_IF,
   input  logic [31:0] i_instruction_data,
   input  logic        i_halt,
   output logic        o_jump,
   output logic        o_branch,
   output logic        o_regDst,
   output logic        o_mem2reg,
   output logic        o_memRead,
   output logic        o_memWrite,
   output logic        o_immediate_flag,
   output logic        o_sign_flag,
   output logic        o_regWrite,
   output logic [1:0]  o_aluSrc,
   output logic [1:0]  o_width,
   output logic [1:0]  o_aluOp,
   output logic [31:0] o_addr2jump,
   output logic [31:0] o_reg_DA,
   output logic [31:0] o_reg_DB,
   output logic [5:0]  o_opcode,
   output logic [5:0]  o_func,
   output logic [4:0]  o_shamt,
   output logic [4:0]  o_rs,
   output logic [4:0]  o_rt,
   output logic [4:0]  o_rd,
   output logic [15:0] o_immediate,
   output logic [31:0] o_ALUresult,
   output logic [1:0]  o_fwA,
   output logic [1:0]  o_fwB,
   output logic [31:0] o_data2mem,
   output logic [7:0]  o_dataAddr,
   output logic [31:0] o_write_dataWB2ID,
   output logic [4:0]  o_reg2writeWB2ID,
   output logic        o_write_enable
);
   typedef struct packed {
      logic jump, branch, reg_dst, mem2reg, mem_read, mem_write, imm_flag, sign_flag, reg_write;
      logic [1:0] alu_src, width, alu_op;
   } ctrl_t;
   typedef struct packed {
      logic reg_dst, mem2reg, mem_read, mem_write, reg_write, imm_op, log_or;
      logic [1:0] alu_op;
      logic [5:0] func;
      logic [4:0] shamt, rs, rt, rd;
      logic [31:0] imm, da, db;
   } idex_t;
   typedef struct packed {
      logic reg_write, mem2reg, mem_write;
      logic [4:0] dst;
      logic [31:0] alu, sdata;
   } exmem_t;
   typedef struct packed {
      logic reg_write, mem2reg;
      logic [4:0] dst;
      logic [31:0] alu, rdata;
   } memwb_t;

   // i_rst_n is active-high despite its name
   logic rst, advance;
   assign rst     = i_rst_n;
   assign advance = !i_we_IF && !i_halt;

   logic [31:0] imem [64];
   logic [31:0] rf   [32];
   logic [31:0] dmem [64];
   logic [5:0]  load_ptr;
   logic [31:0] pc, ifid_ir, ifid_pc4;
   idex_t  idex, idex_n;
   exmem_t exmem, exmem_n;
   memwb_t memwb;
   ctrl_t  ctrl;

   logic [5:0]  opcode, func;
   logic [4:0]  rs, rt, rd, shamt;
   logic [31:0] sext, da, db, wb_data, addr2jump;
   logic        take, stall;

   assign opcode = ifid_ir[31:26];
   assign rs     = ifid_ir[25:21];
   assign rt     = ifid_ir[20:16];
   assign rd     = ifid_ir[15:11];
   assign shamt  = ifid_ir[10:6];
   assign func   = ifid_ir[5:0];
   assign sext   = {{16{ifid_ir[15]}}, ifid_ir[15:0]};

   // the all-zero word is a true NOP, not SLL $0
   always_comb begin
      ctrl = '0;
      if (ifid_ir != 32'd0) begin
         case (opcode)
            6'h00: if (func inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h00, 6'h02}) begin
               ctrl.reg_dst = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu_op = 2'b10;
            end
            6'h02: ctrl.jump = 1'b1;
            6'h04, 6'h05: begin
               ctrl.branch = 1'b1; ctrl.sign_flag = 1'b1; ctrl.alu_op = 2'b01;
            end
            6'h08: begin
               ctrl.reg_write = 1'b1; ctrl.imm_flag = 1'b1; ctrl.sign_flag = 1'b1; ctrl.alu_src = 2'b01;
            end
            6'h0C, 6'h0D: begin
               ctrl.reg_write = 1'b1; ctrl.imm_flag = 1'b1; ctrl.alu_src = 2'b10; ctrl.alu_op = 2'b11;
            end
            6'h23: begin
               ctrl.reg_write = 1'b1; ctrl.mem2reg = 1'b1; ctrl.mem_read = 1'b1; ctrl.imm_flag = 1'b1;
               ctrl.sign_flag = 1'b1; ctrl.alu_src = 2'b01; ctrl.width = 2'b10;
            end
            6'h2B: begin
               ctrl.mem_write = 1'b1; ctrl.imm_flag = 1'b1; ctrl.sign_flag = 1'b1;
               ctrl.alu_src = 2'b01; ctrl.width = 2'b10;
            end
            default: ;
         endcase
      end
   end

   assign wb_data = memwb.mem2reg ? memwb.rdata : memwb.alu;

   always_comb begin
      da = rf[rs];
      db = rf[rt];
      if (memwb.reg_write && memwb.dst == rs) da = wb_data;
      if (memwb.reg_write && memwb.dst == rt) db = wb_data;
      if (rs == 5'd0) da = 32'd0;
      if (rt == 5'd0) db = 32'd0;
   end

   assign addr2jump = ctrl.jump ? {ifid_pc4[31:28], ifid_ir[25:0], 2'b00}
                                : ifid_pc4 + {sext[29:0], 2'b00};
   assign stall = idex.mem_read && idex.rt != 5'd0 && (idex.rt == rs || idex.rt == rt);
   assign take  = !stall && (ctrl.jump || (ctrl.branch && ((opcode == 6'h04) == (da == db))));

   always_comb begin
      idex_n        = '0;
      idex_n.reg_dst   = ctrl.reg_dst;
      idex_n.mem2reg   = ctrl.mem2reg;
      idex_n.mem_read  = ctrl.mem_read;
      idex_n.mem_write = ctrl.mem_write;
      idex_n.reg_write = ctrl.reg_write;
      idex_n.imm_op    = ctrl.alu_src != 2'b00;
      idex_n.log_or    = opcode[0];
      idex_n.alu_op    = ctrl.alu_op;
      idex_n.func      = func;
      idex_n.shamt     = shamt;
      idex_n.rs        = rs;
      idex_n.rt        = rt;
      idex_n.rd        = rd;
      idex_n.imm       = ctrl.sign_flag ? sext : {16'd0, ifid_ir[15:0]};
      idex_n.da        = da;
      idex_n.db        = db;
   end

   // EX: forwarding and ALU
   logic [1:0]  fw_a, fw_b;
   logic [31:0] op_a, rt_val, op_b, alu_res;

   always_comb begin
      fw_a = 2'b00;
      fw_b = 2'b00;
      if (exmem.reg_write && exmem.dst != 5'd0 && exmem.dst == idex.rs) fw_a = 2'b10;
      else if (memwb.reg_write && memwb.dst != 5'd0 && memwb.dst == idex.rs) fw_a = 2'b01;
      if (exmem.reg_write && exmem.dst != 5'd0 && exmem.dst == idex.rt) fw_b = 2'b10;
      else if (memwb.reg_write && memwb.dst != 5'd0 && memwb.dst == idex.rt) fw_b = 2'b01;
      op_a   = (fw_a == 2'b10) ? exmem.alu : (fw_a == 2'b01) ? wb_data : idex.da;
      rt_val = (fw_b == 2'b10) ? exmem.alu : (fw_b == 2'b01) ? wb_data : idex.db;
      op_b   = idex.imm_op ? idex.imm : rt_val;
      case (idex.alu_op)
         2'b01:   alu_res = op_a - op_b;
         2'b11:   alu_res = idex.log_or ? (op_a | op_b) : (op_a & op_b);
         2'b10: begin
            case (idex.func)
               6'h22:   alu_res = op_a - op_b;
               6'h24:   alu_res = op_a & op_b;
               6'h25:   alu_res = op_a | op_b;
               6'h26:   alu_res = op_a ^ op_b;
               6'h2A:   alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
               6'h00:   alu_res = op_b << idex.shamt;
               6'h02:   alu_res = op_b >> idex.shamt;
               default: alu_res = op_a + op_b;
            endcase
         end
         default: alu_res = op_a + op_b;
      endcase
      exmem_n           = '0;
      exmem_n.reg_write = idex.reg_write;
      exmem_n.mem2reg   = idex.mem2reg;
      exmem_n.mem_write = idex.mem_write;
      exmem_n.dst       = idex.reg_dst ? idex.rd : idex.rt;
      exmem_n.alu       = alu_res;
      exmem_n.sdata     = rt_val;
   end

   always_ff @(posedge clk) begin
      if (rst) load_ptr <= 6'd0;
      else if (i_we_IF) load_ptr <= load_ptr + 6'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst && i_we_IF) imem[load_ptr] <= i_instruction_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) rf[i] <= 32'(i);
      end else if (advance && memwb.reg_write && memwb.dst != 5'd0) begin
         rf[memwb.dst] <= wb_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) dmem[i] <= 32'd0;
      end else if (advance && exmem.mem_write) begin
         dmem[exmem.alu[7:2]] <= exmem.sdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc       <= 32'd0;
         ifid_ir  <= 32'd0;
         ifid_pc4 <= 32'd0;
         idex     <= '0;
         exmem    <= '0;
         memwb    <= '0;
      end else if (advance) begin
         if (stall) begin
            idex <= '0;
         end else begin
            idex <= idex_n;
            if (take) begin
               pc       <= addr2jump;
               ifid_ir  <= 32'd0;
               ifid_pc4 <= 32'd0;
            end else begin
               pc       <= pc + 32'd4;
               ifid_ir  <= imem[pc[7:2]];
               ifid_pc4 <= pc + 32'd4;
            end
         end
         exmem           <= exmem_n;
         memwb.reg_write <= exmem.reg_write;
         memwb.mem2reg   <= exmem.mem2reg;
         memwb.dst       <= exmem.dst;
         memwb.alu       <= exmem.alu;
         memwb.rdata     <= dmem[exmem.alu[7:2]];
      end
   end

   assign o_jump            = ctrl.jump;
   assign o_branch          = ctrl.branch;
   assign o_regDst          = ctrl.reg_dst;
   assign o_mem2reg         = ctrl.mem2reg;
   assign o_memRead         = ctrl.mem_read;
   assign o_memWrite        = ctrl.mem_write;
   assign o_immediate_flag  = ctrl.imm_flag;
   assign o_sign_flag       = ctrl.sign_flag;
   assign o_regWrite        = ctrl.reg_write;
   assign o_aluSrc          = ctrl.alu_src;
   assign o_width           = ctrl.width;
   assign o_aluOp           = ctrl.alu_op;
   assign o_addr2jump       = addr2jump;
   assign o_reg_DA          = da;
   assign o_reg_DB          = db;
   assign o_opcode          = opcode;
   assign o_func            = func;
   assign o_shamt           = shamt;
   assign o_rs              = rs;
   assign o_rt              = rt;
   assign o_rd              = rd;
   assign o_immediate       = ifid_ir[15:0];
   assign o_ALUresult       = exmem.alu;
   assign o_fwA             = fw_a;
   assign o_fwB             = fw_b;
   assign o_data2mem        = exmem.sdata;
   assign o_dataAddr        = exmem.alu[7:0];
   assign o_write_dataWB2ID = wb_data;
   assign o_reg2writeWB2ID  = memwb.dst;
   assign o_write_enable    = memwb.reg_write;
endmodule

// File: tb/tb_pipeline.sv
// Directed bench for pipeline: hand-assembled programs, expected values
// worked out by hand from the initial register contents ($i = i).
module tb_pipeline;
   logic        clk = 1'b0;
   logic        rst, we, halt;
   logic [31:0] idata;
   logic        jump, branch, reg_dst, mem2reg, mem_read, mem_write, imm_flag, sign_flag, reg_write;
   logic [1:0]  alu_src, width, alu_op, fw_a, fw_b;
   logic [31:0] addr2jump, reg_da, reg_db, alu_result, data2mem, wb_data;
   logic [5:0]  opcode, func;
   logic [4:0]  shamt, rs, rt, rd, wb_dst;
   logic [15:0] immediate;
   logic [7:0]  data_addr;
   logic        wb_we;

   always #5 clk = ~clk;

   pipeline dut (
      .clk(clk), .i_rst_n(rst), .i_we_IF(we), .i_instruction_data(idata), .i_halt(halt),
      .o_jump(jump), .o_branch(branch), .o_regDst(reg_dst), .o_mem2reg(mem2reg),
      .o_memRead(mem_read), .o_memWrite(mem_write), .o_immediate_flag(imm_flag),
      .o_sign_flag(sign_flag), .o_regWrite(reg_write), .o_aluSrc(alu_src), .o_width(width),
      .o_aluOp(alu_op), .o_addr2jump(addr2jump), .o_reg_DA(reg_da), .o_reg_DB(reg_db),
      .o_opcode(opcode), .o_func(func), .o_shamt(shamt), .o_rs(rs), .o_rt(rt), .o_rd(rd),
      .o_immediate(immediate), .o_ALUresult(alu_result), .o_fwA(fw_a), .o_fwB(fw_b),
      .o_data2mem(data2mem), .o_dataAddr(data_addr), .o_write_dataWB2ID(wb_data),
      .o_reg2writeWB2ID(wb_dst), .o_write_enable(wb_we)
   );

   int n_vec = 0;
   int n_bad = 0;
   logic [31:0] prog [64];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // fills all 64 words so the load pointer wraps back to 0
   task automatic load_prog();
      for (int i = 0; i < 64; i++) begin
         we = 1'b1; idata = prog[i];
         tick();
      end
      we = 1'b0; idata = 32'd0;
   endtask

   task automatic new_prog();
      for (int i = 0; i < 64; i++) prog[i] = 32'd0;
   endtask

   task automatic check_wb(input string tag, input logic e, input logic [4:0] d, input logic [31:0] v);
      check({tag, ".we"}, {31'd0, wb_we}, {31'd0, e});
      if (e) begin
         check({tag, ".dst"}, {27'd0, wb_dst}, {27'd0, d});
         check({tag, ".data"}, wb_data, v);
      end
   endtask

   logic [4:0]  f_dst [14];
   logic [31:0] f_val [14];
   logic        f_we  [14];

   initial begin
      rst = 1'b0; we = 1'b0; halt = 1'b0; idata = 32'd0;

      // reset state
      do_reset();
      check("rst.we", {31'd0, wb_we}, 32'd0);
      check("rst.alu", alu_result, 32'd0);
      check("rst.opcode", {26'd0, opcode}, 32'd0);
      check("rst.regwrite", {31'd0, reg_write}, 32'd0);
      check("rst.addr2jump", addr2jump, 32'd0);
      check("rst.fw", {28'd0, fw_a, fw_b}, 32'd0);
      check("rst.daddr", {24'd0, data_addr}, 32'd0);

      // single ADD $3,$1,$2
      new_prog(); prog[0] = 32'h00221820;
      load_prog();
      tick();
      check("A.rs", {27'd0, rs}, 32'd1);
      check("A.rd", {27'd0, rd}, 32'd3);
      check("A.func", {26'd0, func}, 32'h20);
      check("A.ctrl", {28'd0, reg_dst, reg_write, alu_op}, 32'b1110);
      check("A.DA", reg_da, 32'd1);
      check("A.DB", reg_db, 32'd2);
      tick(); tick();
      check("A.alu", alu_result, 32'd3);
      tick();
      check_wb("A.wb", 1'b1, 5'd3, 32'd3);

      // ADD then dependent SUB: EX/MEM forward
      do_reset();
      new_prog(); prog[0] = 32'h00221820; prog[1] = 32'h00612022;
      load_prog();
      tick(); tick(); tick();
      check("B.fwA", {30'd0, fw_a}, 32'b10);
      check("B.fwB", {30'd0, fw_b}, 32'b00);
      tick();
      check_wb("B.wb_add", 1'b1, 5'd3, 32'd3);
      tick();
      check_wb("B.wb_sub", 1'b1, 5'd4, 32'd2);

      // SW $2,8($1) then LW $5,8($1)
      do_reset();
      new_prog(); prog[0] = 32'hAC220008; prog[1] = 32'h8C250008;
      load_prog();
      tick();
      check("C.sw_ctrl", {28'd0, mem_write, imm_flag, alu_src}, 32'b1101);
      tick(); tick();
      check("C.sw_addr", {24'd0, data_addr}, 32'd9);
      check("C.sw_data", data2mem, 32'd2);
      tick();
      check("C.lw_addr", {24'd0, data_addr}, 32'd9);
      tick();
      check_wb("C.wb_lw", 1'b1, 5'd5, 32'd2);

      // load-use: LW $6,0($0) then ADD $7,$6,$1
      do_reset();
      new_prog(); prog[0] = 32'h8C060000; prog[1] = 32'h00C13820;
      load_prog();
      tick(); tick(); tick();
      check("D.stall_rs", {27'd0, rs}, 32'd6);
      check("D.bubble_alu", alu_result, 32'd0);
      tick();
      check("D.fwA", {30'd0, fw_a}, 32'b01);
      check_wb("D.wb_lw", 1'b1, 5'd6, 32'd0);
      tick(); tick();
      check_wb("D.wb_add", 1'b1, 5'd7, 32'd1);

      // BEQ taken with a 3-cycle halt in the middle
      do_reset();
      new_prog();
      prog[0] = 32'h00221820; prog[1] = 32'h10000002;
      prog[2] = 32'h20080005; prog[3] = 32'h20090009; prog[4] = 32'h200A0007;
      load_prog();
      tick(); tick();
      check("E.branch", {31'd0, branch}, 32'd1);
      check("E.target", addr2jump, 32'd16);
      tick();
      check("E.flush_rt", {27'd0, rt}, 32'd0);
      check("E.alu", alu_result, 32'd3);
      halt = 1'b1;
      tick(); tick(); tick();
      check("E.halt_alu", alu_result, 32'd3);
      check("E.halt_rt", {27'd0, rt}, 32'd0);
      check("E.halt_we", {31'd0, wb_we}, 32'd0);
      halt = 1'b0;
      tick();
      check("E.tgt_rt", {27'd0, rt}, 32'd10);
      check("E.tgt_imm", {16'd0, immediate}, 32'd7);
      check_wb("E.wb_add", 1'b1, 5'd3, 32'd3);
      tick();
      check_wb("E.wb_beq", 1'b0, 5'd0, 32'd0);
      tick();
      check_wb("E.wb_flush", 1'b0, 5'd0, 32'd0);
      tick();
      check_wb("E.wb_addi", 1'b1, 5'd10, 32'd7);

      // ALU ops, $0 handling, BNE not taken
      do_reset();
      new_prog();
      prog[0]  = 32'h00225822; prog[1]  = 32'h00C36024; prog[2]  = 32'h00AA6825;
      prog[3]  = 32'h00E57026; prog[4]  = 32'h0162782A; prog[5]  = 32'h00038100;
      prog[6]  = 32'h001F8882; prog[7]  = 32'h3172FF00; prog[8]  = 32'h34938000;
      prog[9]  = 32'h2034FFFE; prog[10] = 32'h20000005; prog[11] = 32'h0000A820;
      prog[12] = 32'h14210005; prog[13] = 32'h03E1B020;
      f_dst = '{5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd0, 5'd21, 5'd0, 5'd22};
      f_val = '{32'hFFFFFFFF, 32'd2, 32'd15, 32'd2, 32'd1, 32'h30, 32'd7, 32'hFF00, 32'h8004,
                32'hFFFFFFFF, 32'd5, 32'd0, 32'd0, 32'd32};
      f_we  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      load_prog();
      tick(); tick(); tick();
      for (int k = 0; k < 14; k++) begin
         tick();
         check_wb($sformatf("F%0d", k), f_we[k], f_dst[k], f_val[k]);
      end

      // reset mid-run overrides halt and load strobe; imem untouched
      do_reset();
      tick(); tick(); tick();
      rst = 1'b1; halt = 1'b1; we = 1'b1; idata = 32'hFFFFFFFF;
      tick();
      rst = 1'b0; halt = 1'b0; we = 1'b0; idata = 32'd0;
      check("G.alu", alu_result, 32'd0);
      check("G.we", {31'd0, wb_we}, 32'd0);
      check("G.opcode", {26'd0, opcode}, 32'd0);
      tick();
      check("G.rd", {27'd0, rd}, 32'd11);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
